// File: rtl/seq_acc40_pkg.sv
// Shared types and constants for the 40-bit frame accumulator (seq_acc40).
// Optional saturation is selected by macro SEQ_ACC40_SAT_EN in seq_acc40.sv.
package seq_acc40_pkg;

  localparam int DATA_W  = 32;
  localparam int ACC_W   = 40;
  localparam int GUARD_W = ACC_W - DATA_W;

  localparam logic [ACC_W-1:0] SAT_MAX = 40'hFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_acc40_adder.sv
// Combinational 40-bit adder with carry out; the carry is the accumulator's overflow indication.
module acc40_adder
  import seq_acc40_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_acc40.sv
// Frame accumulator: sums N_OPS unsigned 32-bit operands into a 40-bit result with a sticky overflow flag.
// Define SEQ_ACC40_SAT_EN to clamp the sum at SAT_MAX on overflow instead of wrapping modulo 2^40.
module seq_acc40
  import seq_acc40_pkg::*;
#(
  parameter int N_OPS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(N_OPS + 1);

  state_e             state_p0, state_n;
  logic [ACC_W-1:0]   acc_p0, acc_n;
  logic [CNT_W-1:0]   cnt_p0, cnt_n;
  logic               ovf_p0, ovf_n;
  logic               live_p0;
  logic               vld_p0;

  logic [ACC_W-1:0]   add_sum;
  logic               add_cout;
  logic [ACC_W-1:0]   acc_upd;
  logic               accept;
  logic               last_beat;

  acc40_adder u_add (
    .a    (acc_p0),
    .b    ({{GUARD_W{1'b0}}, in_data}),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef SEQ_ACC40_SAT_EN
  // Once the frame has overflowed the sum stays pinned at full scale.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] sum, input logic ovf);
    return ovf ? SAT_MAX : sum;
  endfunction

  assign acc_upd = sat_acc(add_sum, add_cout | ovf_p0);
`else
  assign acc_upd = add_sum;
`endif

  // live_p0 keeps in_ready low until the first edge after reset release.
  assign in_ready  = live_p0 && (state_p0 != HOLD);
  assign accept    = in_valid && in_ready && !in_clr;
  assign last_beat = (cnt_p0 == CNT_W'(N_OPS - 1));

  always_comb begin
    state_n = state_p0;
    acc_n   = acc_p0;
    cnt_n   = cnt_p0;
    ovf_n   = ovf_p0;
    if (in_clr) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      unique case (state_p0)
        IDLE: begin
          if (accept) begin
            acc_n   = {{GUARD_W{1'b0}}, in_data};
            cnt_n   = CNT_W'(1);
            ovf_n   = 1'b0;
            state_n = (N_OPS == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_n = acc_upd;
            cnt_n = cnt_p0 + CNT_W'(1);
            ovf_n = ovf_p0 | add_cout;
            if (last_beat) state_n = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
      endcase
    end
  end

  // Stage p0: accumulator state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      acc_p0   <= '0;
      cnt_p0   <= '0;
      ovf_p0   <= 1'b0;
      live_p0  <= 1'b0;
    end else begin
      state_p0 <= state_n;
      acc_p0   <= acc_n;
      cnt_p0   <= cnt_n;
      ovf_p0   <= ovf_n;
      live_p0  <= 1'b1;
    end
  end

  assign vld_p0    = (state_p0 == HOLD);
  assign out_valid = vld_p0;
  assign out_sum   = vld_p0 ? acc_p0 : '0;
  assign out_ovf   = vld_p0 & ovf_p0;

endmodule

// File: tb/tb_seq_acc40.sv
// Directed bench for seq_acc40: five instances (N_OPS = 8, 4, 2, 1024, 1) share all inputs.
module tb_seq_acc40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_clr;
  logic        out_ready;

  logic        r8, r4, r2, rk, r1;
  logic        v8, v4, v2, vk, v1;
  logic [39:0] s8, s4, s2, sk, s1;
  logic        o8, o4, o2, ok, o1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_acc40 #(.N_OPS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r8), .in_data(in_data),
    .in_clr(in_clr), .out_valid(v8), .out_ready(out_ready), .out_sum(s8), .out_ovf(o8));
  seq_acc40 #(.N_OPS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r4), .in_data(in_data),
    .in_clr(in_clr), .out_valid(v4), .out_ready(out_ready), .out_sum(s4), .out_ovf(o4));
  seq_acc40 #(.N_OPS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
    .in_clr(in_clr), .out_valid(v2), .out_ready(out_ready), .out_sum(s2), .out_ovf(o2));
  seq_acc40 #(.N_OPS(1024)) uk (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rk), .in_data(in_data),
    .in_clr(in_clr), .out_valid(vk), .out_ready(out_ready), .out_sum(sk), .out_ovf(ok));
  seq_acc40 #(.N_OPS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
    .in_clr(in_clr), .out_valid(v1), .out_ready(out_ready), .out_sum(s1), .out_ovf(o1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_all();
    in_valid = 1'b0;
    in_clr   = 1'b1;
    tick();
    in_clr   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_clr = 1'b0; out_ready = 1'b0;

    // reset state, before and across clock edges
    #3;
    chk("rst_in_ready", r8, 1'b0);
    chk("rst_out_valid", v8, 1'b0);
    chk("rst_out_sum", s8, 40'd0);
    chk("rst_out_ovf", o8, 1'b0);
    tick(); tick();
    chk("rst_hold_in_ready", r4, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", r8, 1'b1);

    // N_OPS=8: operands 1..8 back-to-back -> 36, valid for exactly one cycle
    clr_all();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      if (i == 7) chk("sum8_no_early_valid", v8, 1'b0);
    end
    in_valid = 1'b0;
    chk("sum8_valid", v8, 1'b1);
    chk("sum8_sum", s8, 40'd36);
    chk("sum8_ovf", o8, 1'b0);
    chk("sum8_in_ready_hold", r8, 1'b0);
    tick();
    chk("sum8_valid_drop", v8, 1'b0);
    chk("sum8_sum_zero", s8, 40'd0);
    chk("sum8_in_ready_idle", r8, 1'b1);

    // N_OPS=4: four all-ones operands -> 3_FFFF_FFFC, no overflow
    clr_all();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
      tick();
    end
    in_valid = 1'b0;
    chk("max4_valid", v4, 1'b1);
    chk("max4_sum", s4, 40'h3_FFFF_FFFC);
    chk("max4_ovf", o4, 1'b0);
    tick();
    chk("max4_valid_drop", v4, 1'b0);

    // N_OPS=2: backpressure for 5 cycles with in_valid held high
    clr_all();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd5; tick();
    in_data = 32'd7; tick();
    in_data = 32'd100;
    for (int k = 0; k < 5; k++) begin
      chk("bp2_valid", v2, 1'b1);
      chk("bp2_sum", s2, 40'd12);
      chk("bp2_in_ready", r2, 1'b0);
      tick();
    end
    chk("bp2_sum_last", s2, 40'd12);
    out_ready = 1'b1;
    tick();
    chk("bp2_release_valid", v2, 1'b0);
    chk("bp2_release_in_ready", r2, 1'b1);
    chk("bp2_release_sum", s2, 40'd0);
    tick();
    in_data = 32'd1; tick();
    in_valid = 1'b0;
    chk("bp2_next_valid", v2, 1'b1);
    chk("bp2_next_sum", s2, 40'd101);
    tick();

    // N_OPS=8: abort after 3 operands (concurrent beat discarded), then 8 x 2 -> 16
    clr_all();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'd9; tick();
    end
    in_clr = 1'b1; tick();
    in_clr = 1'b0;
    chk("clr8_valid", v8, 1'b0);
    chk("clr8_in_ready", r8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'd2; tick();
    end
    in_valid = 1'b0;
    chk("clr8_valid_after", v8, 1'b1);
    chk("clr8_sum", s8, 40'd16);
    chk("clr8_ovf", o8, 1'b0);
    tick();

    // N_OPS=1: single-beat frame, then in_clr beats a concurrent result transfer
    clr_all();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd42; tick();
    in_valid = 1'b0;
    chk("one_valid", v1, 1'b1);
    chk("one_sum", s1, 40'd42);
    out_ready = 1'b1; in_clr = 1'b1; tick();
    in_clr = 1'b0;
    chk("one_clr_valid", v1, 1'b0);
    chk("one_clr_sum", s1, 40'd0);

    // N_OPS=1024: all-ones frame overflows 40 bits
    clr_all();
    for (int i = 1; i <= 1024; i++) begin
      in_valid = 1'b1; in_data = 32'hFFFF_FFFF; tick();
      if (i == 1023) chk("big_no_early_valid", vk, 1'b0);
    end
    in_valid = 1'b0;
    chk("big_valid", vk, 1'b1);
`ifdef SEQ_ACC40_SAT_EN
    chk("big_sum", sk, 40'hFF_FFFF_FFFF);
`else
    chk("big_sum", sk, 40'hFF_FFFF_FC00);
`endif
    chk("big_ovf", ok, 1'b1);
    tick();
    chk("big_valid_drop", vk, 1'b0);
    chk("big_ovf_drop", ok, 1'b0);

    // N_OPS=8: reset mid-frame after 5 operands, then a full frame of 1s
    clr_all();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'd1; tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", r8, 1'b0);
    chk("midrst_valid", v8, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_ready_back", r8, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'd1; tick();
      if (i < 8) chk("midrst_no_early_valid", v8, 1'b0);
    end
    in_valid = 1'b0;
    chk("midrst_valid_final", v8, 1'b1);
    chk("midrst_sum", s8, 40'd8);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_acc40.md
SEQ_ACC40 -- requirements
Module: seq_acc40

Interface
REQ-001 SHALL have parameter N_OPS, default 8, meaning operands per frame (legal range 1..1024).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning the operand on in_data is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept an operand this cycle.
REQ-006 SHALL have port in_data, input, 32, unsigned operand.
REQ-007 SHALL have port in_clr, input, 1, synchronous frame abort.
REQ-008 SHALL have port out_valid, output, 1, meaning out_sum and out_ovf hold a completed frame result.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 SHALL have port out_sum, output, 40, the frame sum (32-bit operands plus 8 guard bits).
REQ-011 SHALL have port out_ovf, output, 1, sticky flag: the frame sum exceeded 40 bits.

Function
REQ-012 SHALL implement states IDLE (no operand yet), ACCUM (1..N_OPS-1 operands taken) and HOLD (result presented).
REQ-013 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD; combinational from state only, never from in_valid.
REQ-014 SHALL accept an operand exactly on cycles with in_valid && in_ready && !in_clr.
REQ-015 SHALL, on acceptance in IDLE, load acc = zero-extended in_data, count=1 and ovf=0, then go to ACCUM, or to HOLD when N_OPS==1.
REQ-016 SHALL, on acceptance in ACCUM, set acc = acc + zero-extended in_data (40-bit add) and increment count.
REQ-017 SHALL treat a carry out of bit 39 as overflow: set ovf, and store the wrapped 40-bit result.
REQ-018 SHALL, on acceptance of the N_OPS-th operand, go to HOLD; out_valid rises the next cycle, giving a latency of 1 clock from the last accepted beat.
REQ-019 SHALL keep out_sum=acc and out_ovf=ovf stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, in HOLD with out_ready=1, complete the transfer and return to IDLE with acc=0, count=0 and ovf=0; out_valid is 0 the next cycle, and no operand is accepted in that same cycle.
REQ-021 SHALL give in_clr priority over all other events in any state: next state IDLE, acc/count/ovf cleared, out_valid=0 next cycle, and the concurrent operand or result transfer discarded.
REQ-022 SHALL hold state unchanged when in_valid=0 in ACCUM; frames have no timeout.
REQ-023 SHALL drive out_sum=0 and out_ovf=0 whenever out_valid=0.
REQ-024 SHALL size count as clog2(N_OPS+1) bits; count never exceeds N_OPS.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, acc=0, count=0, ovf=0, out_valid=0, in_ready=0, out_sum=0 and out_ovf=0.
REQ-026 SHALL drive in_ready=1 on the first clock edge after rst_n deasserts.
REQ-027 SHALL discard a frame in progress when reset asserts; no partial result is ever presented.

Configuration
REQ-028 SHALL honour macro SEQ_ACC40_SAT_EN.
REQ-029 SHALL, when SEQ_ACC40_SAT_EN is defined, clamp acc to 40'hFF_FFFF_FFFF on overflow and keep it clamped for the rest of the frame, with ovf=1.
REQ-030 SHALL, when SEQ_ACC40_SAT_EN is undefined, wrap modulo 2^40 per REQ-017, with no saturation logic synthesized.

Structure
REQ-031 SHALL take its state enum (IDLE/ACCUM/HOLD), ACC_W=40, DATA_W=32 and SAT_MAX constant from the shared package seq_acc40_pkg.
REQ-032 SHALL instantiate one combinational sub-module, acc40_adder: 40-bit + 40-bit inputs, giving a 40-bit sum and a carry out.

Verification
REQ-033 Bench SHALL cover: N_OPS=8, operands 1..8 back-to-back, out_ready=1 -> out_sum=36, out_ovf=0, out_valid for exactly 1 cycle.
REQ-034 Bench SHALL cover: N_OPS=4, four operands 32'hFFFF_FFFF -> out_sum=40'h3_FFFF_FFFC, out_ovf=0.
REQ-035 Bench SHALL cover: N_OPS=2, out_ready=0 for 5 cycles after out_valid -> out_sum stable, in_ready=0 and in_valid ignored throughout, IDLE after release.
REQ-036 Bench SHALL cover: N_OPS=8, in_clr after 3 operands, then 8 operands of value 2 -> out_sum=16.
REQ-037 Bench SHALL cover: N_OPS=1024, all operands 32'hFFFF_FFFF -> out_sum=40'hFF_FFFF_FC00 with out_ovf=1, or 40'hFF_FFFF_FFFF with out_ovf=1 when SEQ_ACC40_SAT_EN is defined.
REQ-038 Bench SHALL cover: rst_n pulsed low after 5 operands, then a full frame of 1s -> out_sum=N_OPS, with no earlier out_valid.
